// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to a Fibonacci LFSR word stream,
// then free-runs and accumulates word/bit error statistics while locked.
//
// state  | meaning
// -------+--------------------------------------------------------------
// SEARCH | re-seeding from every received word, counting good predictions
// LOCKED | free-running prediction, checking and counting every valid word
module lfsr_checker #(
    parameter int              WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hD008,
    parameter int              LOCK_COUNT = 8,
    parameter int              LOSS_COUNT = 4,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prn_valid,
    input  logic [WIDTH-1:0] prn,
    input  logic             clear_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_err_count,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + PC_W'(v[i]);
        return n;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             ref_ok_q, ref_ok_d;
    logic [7:0]       match_q, match_d;
    logic [7:0]       miss_q, miss_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_err_q, bit_err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic [WIDTH-1:0] exp_w;
    logic [SUM_W-1:0] bit_sum;

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        ref_ok_d    = ref_ok_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_err_d   = bit_err_q;
        word_cnt_d  = word_cnt_q;
        exp_w       = step(ref_q);
        bit_sum     = SUM_W'(bit_err_q) + SUM_W'(popcount(prn ^ exp_w));

        if (prn_valid) begin
            case (state_q)
                SEARCH: begin
                    if (prn == '0) begin
                        ref_ok_d = 1'b0;
                        match_d  = '0;
                    end else begin
                        ref_d    = prn;
                        ref_ok_d = 1'b1;
                        match_d  = (ref_ok_q && prn == exp_w) ? match_q + 8'd1 : 8'd0;
                        if (match_d == 8'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end
                end
                LOCKED: begin
                    ref_d      = exp_w;
                    word_cnt_d = (word_cnt_q == CNT_MAX) ? word_cnt_q : word_cnt_q + CNT_W'(1);
                    if (prn != exp_w) begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_W'(1);
                        bit_err_d   = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
                        miss_d      = miss_q + 8'd1;
                        if (miss_d == 8'(LOSS_COUNT)) begin
                            state_d  = SEARCH;
                            match_d  = '0;
                            ref_d    = prn;
                            ref_ok_d = (prn != '0);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear wins over a same-cycle increment; the error pulse is unaffected.
        if (clear_counts) begin
            err_cnt_d  = '0;
            bit_err_d  = '0;
            word_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            ref_q       <= '0;
            ref_ok_q    <= 1'b0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_err_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            ref_ok_q    <= ref_ok_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_err_q   <= bit_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign locked        = (state_q == LOCKED);
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_cnt_q;
    assign bit_err_count = bit_err_q;
    assign word_count    = word_cnt_q;

endmodule
